// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants for the fetch/decode pipeline registers
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // ID/EX control bundle layout
    localparam int CTRL_W       = 10;
    localparam int CTRL_REGWR   = 0;
    localparam int CTRL_MEMRD   = 1;
    localparam int CTRL_MEMWR   = 2;
    localparam int CTRL_MEM2REG = 3;
    localparam int CTRL_ALUSRC  = 4;
    localparam int CTRL_ALUOP0  = 5;
    localparam int CTRL_ALUOP1  = 6;
    localparam int CTRL_BRANCH  = 7;
    localparam int CTRL_JUMP    = 8;
    localparam int CTRL_SPARE   = 9;

    localparam int          PC_STEP       = 4;
    localparam logic [63:0] RESET_PC      = 64'h0;
    localparam int          MAX_STALL_DEF = 2;

endpackage

// File: rtl/stall_monitor.sv
// rtl/stall_monitor.sv - load-use stall watchdog with sticky protocol error
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc_write            0 = PC held this cycle
//   if_id_write         must agree with pc_write unless flushing
//   branch_flush        flush cycle, clears the consecutive-stall count
//   stall_error         sticky, cleared only by rst
module stall_monitor
    import pipe_pkg::*;
#(
    parameter int MAX_STALL = MAX_STALL_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic pc_write,
    input  logic if_id_write,
    input  logic branch_flush,
    output logic stall_error
);

    localparam int              CNT_W = $clog2(MAX_STALL + 2);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(MAX_STALL + 1);

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             stall_cycle;
    logic             mismatch;

    assign stall_cycle = !pc_write && !branch_flush;
    assign mismatch    = !branch_flush && (pc_write != if_id_write);

    always_comb begin
        cnt_next = '0;
        if (stall_cycle) begin
            cnt_next = (stall_cnt == SAT) ? SAT : stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt   <= '0;
            stall_error <= 1'b0;
        end else begin
            stall_cnt <= cnt_next;
            // Flag on the same edge the count first reaches the limit
            if ((stall_cycle && cnt_next == SAT) || mismatch) begin
                stall_error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stall_ctrl.sv
// rtl/fetch_stall_ctrl.sv - PC, IF/ID and ID/EX control registers obeying hazard/flush handshake
// Optional: STALL_PERF_EN adds perf_stall_cycles / perf_flush_cycles outputs.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   pc_write, if_id_write           hazard unit hold controls (0 = hold)
//   hazard_detected                 1 = bubble into ID/EX control
//   branch_flush, branch_target     MEM-stage redirect
//   imem_instr                      instruction read at imem_addr
//   id_ctrl                         decoded control bundle
//   imem_addr                       PC register
//   if_id_pc, if_id_instr           IF/ID register
//   id_ex_ctrl                      ID/EX control register
//   stall_active                    PC held this cycle (combinational)
//   stall_error                     sticky protocol violation
module fetch_stall_ctrl #(
    parameter int                ADDR_W    = 64,
    parameter int                INSTR_W   = 32,
    parameter int                CTRL_W    = pipe_pkg::CTRL_W,
    parameter int                PC_STEP   = pipe_pkg::PC_STEP,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(pipe_pkg::NOP_INSTR),
    parameter int                MAX_STALL = pipe_pkg::MAX_STALL_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(pipe_pkg::RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_write,
    input  logic               if_id_write,
    input  logic               hazard_detected,
    input  logic               branch_flush,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic [CTRL_W-1:0]  id_ctrl,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [CTRL_W-1:0]  id_ex_ctrl,
    output logic               stall_active,
`ifdef STALL_PERF_EN
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_flush_cycles,
`endif
    output logic               stall_error
);

    logic [ADDR_W-1:0] pc;

    assign imem_addr    = pc;
    assign stall_active = !pc_write && !branch_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            id_ex_ctrl  <= '0;
        end else if (branch_flush) begin
            pc          <= branch_target;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            id_ex_ctrl  <= '0;
        end else begin
            if (pc_write) begin
                pc <= pc + ADDR_W'(PC_STEP);
            end
            if (if_id_write) begin
                if_id_pc    <= pc;
                if_id_instr <= imem_instr;
            end
            id_ex_ctrl <= hazard_detected ? '0 : id_ctrl;
        end
    end

`ifdef STALL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_cycles <= '0;
        end else begin
            if (stall_active) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (branch_flush) begin
                perf_flush_cycles <= perf_flush_cycles + 32'd1;
            end
        end
    end
`endif

    stall_monitor #(
        .MAX_STALL (MAX_STALL)
    ) u_stall_monitor (
        .clk          (clk),
        .rst          (rst),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .branch_flush (branch_flush),
        .stall_error  (stall_error)
    );

endmodule
